// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal register: operation-select width and encodings.
package univ_reg_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
   localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
   localparam logic [MODE_W-1:0] MODE_INC  = 3'd6;
   localparam logic [MODE_W-1:0] MODE_DEC  = 3'd7;

endpackage

// File: rtl/dffr_pe_async_rsth.sv
// Positive-edge register with clock enable and active-high asynchronous reset to RST_VAL.
module dffr_pe_async_rsth #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/univ_reg_async_rst.sv
// WIDTH-bit universal register: hold/load/shift/rotate/count with clear, serial I/O
// and a one-cycle wrap pulse; the next-state mux lives here, storage in dffr_pe_async_rsth.
module univ_reg_async_rst
   import univ_reg_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              sin_l,
   input  logic              sin_r,
   output logic [WIDTH-1:0]  q,
   output logic              sout_l,
   output logic              sout_r,
   output logic              wrap,
   output logic              zero
);

   logic [WIDTH-1:0] q_next;
   logic             wrap_next;
   logic             wrap_d;

   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      if (clr) begin
         q_next = '0;
      end else begin
         case (mode)
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
            MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_INC: begin
               q_next    = q + WIDTH'(1);
               wrap_next = &q;
            end
            MODE_DEC: begin
               q_next    = q - WIDTH'(1);
               wrap_next = ~|q;
            end
            default:   q_next = q;
         endcase
      end
   end

   // wrap is a pulse: its register is always clocked so a disabled edge also clears it
   assign wrap_d = en & wrap_next;

   dffr_pe_async_rsth #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
   ) u_q_reg (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (q_next),
      .q   (q)
   );

   dffr_pe_async_rsth #(
      .WIDTH   (1),
      .RST_VAL (1'b0)
   ) u_wrap_reg (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .d   (wrap_d),
      .q   (wrap)
   );

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];
   assign zero   = (q == '0);

endmodule

// File: tb/tb_univ_reg_async_rst.sv
// Scoreboard bench for univ_reg_async_rst (WIDTH=8, RST_VAL=8'hA5): directed scenarios
// followed by random traffic, checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_univ_reg_async_rst;

   localparam int         W   = 8;
   localparam logic [7:0] RV  = 8'hA5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [7:0] d = 8'd0;
   logic       sin_l = 1'b0;
   logic       sin_r = 1'b0;
   logic [7:0] q;
   logic       sout_l, sout_r, wrap, zero;

   univ_reg_async_rst #(.WIDTH(W), .RST_VAL(RV)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .d(d),
      .sin_l(sin_l), .sin_r(sin_r), .q(q), .sout_l(sout_l), .sout_r(sout_r),
      .wrap(wrap), .zero(zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    q;
      int    w;
      string tag;
   } exp_t;

   exp_t sb[$];
   event chk_ev;
   int   total = 0;
   int   bad = 0;
   int   m_q = 0;
   int   m_w = 0;

   // reference model: one rising edge, computed with plain integer arithmetic
   function automatic void model_edge(input int e, input int c, input int md,
                                      input int dv, input int sl, input int sr);
      int nq;
      int nw;
      nq = m_q;
      nw = 0;
      if (rst) begin
         nq = int'(RV);
      end else if (e != 0) begin
         if (c != 0) nq = 0;
         else begin
            case (md)
               1: nq = dv;
               2: nq = (m_q * 2 + sl) % 256;
               3: nq = m_q / 2 + sr * 128;
               4: nq = (m_q * 2) % 256 + m_q / 128;
               5: nq = m_q / 2 + (m_q % 2) * 128;
               6: begin nq = (m_q + 1) % 256;   nw = (m_q == 255) ? 1 : 0; end
               7: begin nq = (m_q + 255) % 256; nw = (m_q == 0) ? 1 : 0; end
               default: nq = m_q;
            endcase
         end
      end
      m_q = nq;
      m_w = nw;
   endfunction

   task automatic push(input string tag);
      exp_t x;
      x.q = m_q;
      x.w = m_w;
      x.tag = tag;
      sb.push_back(x);
   endtask

   task automatic step(input string tag, input logic e, input logic c, input logic [2:0] md,
                       input logic [7:0] dv, input logic sl, input logic sr);
      en = e; clr = c; mode = md; d = dv; sin_l = sl; sin_r = sr;
      @(posedge clk);
      model_edge(int'(e), int'(c), int'(md), int'(dv), int'(sl), int'(sr));
      push(tag);
      #1 -> chk_ev;
   endtask

   task automatic rst_pulse(input string tag);
      #2 rst = 1'b1;
      m_q = int'(RV);
      m_w = 0;
      push(tag);
      #0.5 -> chk_ev;
      #0.5 rst = 1'b0;
   endtask

   task automatic cmp(input string name, input string tag, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s [%s]: got %0h expected %0h", name, tag, act, exp_v);
      end
   endtask

   // monitor: drains the scoreboard whenever a sample point is signalled
   initial begin
      exp_t x;
      forever begin
         @(chk_ev);
         while (sb.size() > 0) begin
            x = sb.pop_front();
            cmp("q", x.tag, int'(q), x.q);
            cmp("wrap", x.tag, int'(wrap), x.w);
            cmp("zero", x.tag, int'(zero), (x.q == 0) ? 1 : 0);
            cmp("sout_l", x.tag, int'(sout_l), x.q / 128);
            cmp("sout_r", x.tag, int'(sout_r), x.q % 2);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      // reset asserted between clock edges must act immediately
      #2 rst = 1'b1;
      m_q = int'(RV); m_w = 0;
      push("async_rst");
      #1 -> chk_ev;
      for (int i = 0; i < 3; i++) step("rst_hold", 1'b1, 1'b0, 3'd1, 8'hFF, 1'b0, 1'b0);
      #1 rst = 1'b0;

      step("load81", 1'b1, 1'b0, 3'd1, 8'b1000_0001, 1'b0, 1'b0);
      step("shl", 1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0);
      step("shr", 1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b1);
      step("rol", 1'b1, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0);
      step("ror1", 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0);
      step("ror2", 1'b1, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0);
      step("load5a", 1'b1, 1'b0, 3'd1, 8'h5A, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step("rol8", 1'b1, 1'b0, 3'd4, 8'h00, 1'b1, 1'b1);
      step("loadfe", 1'b1, 1'b0, 3'd1, 8'hFE, 1'b0, 1'b0);
      step("inc1", 1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
      step("inc_wrap", 1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
      step("dec_wrap", 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0);
      step("en0_clr", 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
      step("loadff", 1'b1, 1'b0, 3'd1, 8'hFF, 1'b0, 1'b0);
      step("clr_inc", 1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
      step("load0e", 1'b1, 1'b0, 3'd1, 8'h0E, 1'b0, 1'b0);
      step("inc_run", 1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
      step("inc_run", 1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
      rst_pulse("mid_rst");
      step("inc_resume", 1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);
      step("inc_resume", 1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < 400; i++) begin
         logic       e;
         logic       c;
         logic [2:0] md;
         logic [7:0] dv;
         e  = ($urandom_range(0, 7) != 0);
         c  = ($urandom_range(0, 15) == 0);
         md = 3'($urandom_range(0, 7));
         dv = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         if (md == 3'd1 && $urandom_range(0, 3) == 0) dv = 8'h00;
         if ($urandom_range(0, 40) == 0) rst_pulse("rand_rst");
         else step("random", e, c, md, dv, 1'($urandom), 1'($urandom));
      end

      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
